// File: rtl/alu_exec_ctrl.sv
// Single-issue ALU execution controller: one-cycle decode/execute for simple ops,
// multi-cycle shift-add multiplier retiring MUL_STEP multiplier bits per clock.
module alu_exec_ctrl #(
    parameter int DATA_W   = 21,
    parameter int MUL_STEP = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4:0]        op,
    input  logic [2:0]        func,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [2:0]        alu_op,
    output logic [DATA_W-1:0] result,
    output logic              zero,
    output logic              illegal,
    output logic              out_valid,
    output logic              o_dbg_state
);

    localparam int K     = (DATA_W + MUL_STEP - 1) / MUL_STEP;
    localparam int CNT_W = $clog2(K + 1);

    localparam logic [4:0] OP_RTYPE = 5'b00000;
    localparam logic [4:0] OP_ORI   = 5'b11000;
    localparam logic [4:0] OP_SLTI  = 5'b10010;
    localparam logic [4:0] OP_ADDI  = 5'b00100;
    localparam logic [4:0] OP_LW    = 5'b01000;
    localparam logic [4:0] OP_SW    = 5'b01100;
    localparam logic [4:0] OP_J     = 5'b00111;
    localparam logic [4:0] OP_BEQ   = 5'b01111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b100;
    localparam logic [2:0] ALU_MUL = 3'b101;
    localparam logic [2:0] ALU_ILL = 3'b111;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [2:0]          r_alu_op;
    logic [DATA_W-1:0]   r_result;
    logic                r_zero;
    logic                r_illegal;
    logic                r_out_valid;
    logic [DATA_W-1:0]   r_acc;
    logic [DATA_W-1:0]   r_mcand;
    logic [DATA_W-1:0]   r_mplier;
    logic [CNT_W-1:0]    r_cnt;

    logic [2:0]          w_dec;
    logic [DATA_W-1:0]   w_res;
    logic [DATA_W-1:0]   w_pp;
    logic [DATA_W-1:0]   w_acc_nxt;
    logic                w_accept;
    logic                w_is_mul;
    logic                w_last;

    // Handshake: a request transfers on a rising edge where in_valid and in_ready
    // are both 1; in_ready is 1 exactly while idle, so in_valid is ignored when busy.
    assign in_ready    = (r_state == S_IDLE);
    assign w_accept    = in_valid && in_ready;
    assign w_is_mul    = (w_dec == ALU_MUL);
    assign w_last      = (r_cnt == CNT_W'(K - 1));
    assign w_acc_nxt   = r_acc + w_pp;

    assign alu_op      = r_alu_op;
    assign result      = r_result;
    assign zero        = r_zero;
    assign illegal     = r_illegal;
    assign out_valid   = r_out_valid;
    assign o_dbg_state = r_state;

    always_comb begin
        w_dec = ALU_ADD;
        if (op == OP_RTYPE) begin
            case (func)
                3'b010:  w_dec = ALU_ADD;
                3'b001:  w_dec = ALU_SUB;
                3'b011:  w_dec = ALU_AND;
                3'b100:  w_dec = ALU_MUL;
                default: w_dec = ALU_ILL;
            endcase
        end else begin
            case (op)
                OP_ORI:                      w_dec = ALU_OR;
                OP_SLTI:                     w_dec = ALU_SLT;
                OP_BEQ:                      w_dec = ALU_SUB;
                OP_ADDI, OP_LW, OP_SW, OP_J: w_dec = ALU_ADD;
                default:                     w_dec = ALU_ADD;
            endcase
        end
    end

    always_comb begin
        w_res = '0;
        case (w_dec)
            ALU_ADD: w_res = a + b;
            ALU_SUB: w_res = a - b;
            ALU_AND: w_res = a & b;
            ALU_OR:  w_res = a | b;
            ALU_SLT: w_res = ($signed(a) < $signed(b)) ? DATA_W'(1) : '0;
            default: w_res = '0;
        endcase
    end

    // Multiplier bits shifted past the top arrive as zeros, which covers a short final step.
    always_comb begin
        w_pp = '0;
        for (int i = 0; i < MUL_STEP; i++) begin
            if (r_mplier[i]) begin
                w_pp = w_pp + (r_mcand << i);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept && w_is_mul) begin
                    w_state_nxt = S_MUL;
                end
            end
            S_MUL: begin
                if (w_last) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_alu_op    <= ALU_ADD;
            r_result    <= '0;
            r_zero      <= 1'b1;
            r_illegal   <= 1'b0;
            r_out_valid <= 1'b0;
            r_acc       <= '0;
            r_mcand     <= '0;
            r_mplier    <= '0;
            r_cnt       <= '0;
        end else begin
            r_out_valid <= 1'b0;
            if (w_accept) begin
                r_alu_op <= w_dec;
                if (w_is_mul) begin
                    r_acc    <= '0;
                    r_mcand  <= a;
                    r_mplier <= b;
                    r_cnt    <= '0;
                end else begin
                    r_result    <= w_res;
                    r_zero      <= (w_res == '0);
                    r_illegal   <= (w_dec == ALU_ILL);
                    r_out_valid <= 1'b1;
                end
            end else if (r_state == S_MUL) begin
                r_mcand  <= r_mcand << MUL_STEP;
                r_mplier <= r_mplier >> MUL_STEP;
                if (w_last) begin
                    r_result    <= w_acc_nxt;
                    r_zero      <= (w_acc_nxt == '0);
                    r_illegal   <= 1'b0;
                    r_out_valid <= 1'b1;
                    r_acc       <= '0;
                    r_cnt       <= '0;
                end else begin
                    r_acc <= w_acc_nxt;
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Bench for alu_exec_ctrl: directed and random requests checked against an
// arithmetic reference model, with MUL_STEP=1 and MUL_STEP=4 instances.
module tb_alu_exec_ctrl;

    localparam int DW = 21;

    logic          clk = 1'b0;
    logic          rst;
    logic [4:0]    op;
    logic [2:0]    func;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic          in_valid1;
    logic          in_valid4;
    logic          sel;

    logic          ready1, zero1, illegal1, ovalid1, dbg1;
    logic [2:0]    aluop1;
    logic [DW-1:0] result1;
    logic          ready4, zero4, illegal4, ovalid4, dbg4;
    logic [2:0]    aluop4;
    logic [DW-1:0] result4;

    logic          s_ready, s_zero, s_illegal, s_ovalid;
    logic [2:0]    s_aluop;
    logic [DW-1:0] s_result;

    int            checks   = 0;
    int            failures = 0;
    logic [DW-1:0] exp_q[$];
    logic [4:0]    op_tab [0:8] = '{5'b00000, 5'b11000, 5'b10010, 5'b00100, 5'b01000,
                                    5'b01100, 5'b00111, 5'b01111, 5'b11111};

    // clock / reset infrastructure
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    alu_exec_ctrl #(.DATA_W(DW), .MUL_STEP(1)) u_dut1 (
        .clk(clk), .rst(rst), .op(op), .func(func), .a(a), .b(b),
        .in_valid(in_valid1), .in_ready(ready1), .alu_op(aluop1), .result(result1),
        .zero(zero1), .illegal(illegal1), .out_valid(ovalid1), .o_dbg_state(dbg1)
    );

    alu_exec_ctrl #(.DATA_W(DW), .MUL_STEP(4)) u_dut4 (
        .clk(clk), .rst(rst), .op(op), .func(func), .a(a), .b(b),
        .in_valid(in_valid4), .in_ready(ready4), .alu_op(aluop4), .result(result4),
        .zero(zero4), .illegal(illegal4), .out_valid(ovalid4), .o_dbg_state(dbg4)
    );

    assign s_ready  = sel ? ready4   : ready1;
    assign s_aluop  = sel ? aluop4   : aluop1;
    assign s_result = sel ? result4  : result1;
    assign s_zero   = sel ? zero4    : zero1;
    assign s_illegal = sel ? illegal4 : illegal1;
    assign s_ovalid = sel ? ovalid4  : ovalid1;

    // reference model
    function automatic logic [2:0] model_dec(input logic [4:0] o, input logic [2:0] f);
        if (o == 5'b00000) begin
            if (f == 3'b010) return 3'b000;
            if (f == 3'b001) return 3'b001;
            if (f == 3'b011) return 3'b010;
            if (f == 3'b100) return 3'b101;
            return 3'b111;
        end
        if (o == 5'b11000) return 3'b011;
        if (o == 5'b10010) return 3'b100;
        if (o == 5'b01111) return 3'b001;
        return 3'b000;
    endfunction

    function automatic logic [DW-1:0] model_res(input logic [2:0] d, input logic [DW-1:0] x,
                                                input logic [DW-1:0] y);
        logic [2*DW-1:0] p;
        p = {{DW{1'b0}}, x} * {{DW{1'b0}}, y};
        case (d)
            3'b000:  return x + y;
            3'b001:  return x - y;
            3'b010:  return x & y;
            3'b011:  return x | y;
            3'b100:  return ($signed(x) < $signed(y)) ? DW'(1) : DW'(0);
            3'b101:  return p[DW-1:0];
            default: return '0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] ex);
        checks++;
        assert (obs === ex) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, ex);
        end
    endtask

    // driver tasks
    task automatic set_valid(input logic v);
        if (sel) in_valid4 = v;
        else     in_valid1 = v;
    endtask

    task automatic run_req(input logic s, input logic [4:0] o, input logic [2:0] f,
                           input logic [DW-1:0] aa, input logic [DW-1:0] bb,
                           input bit scramble, input string tag);
        logic [2:0]    d;
        logic [DW-1:0] r;
        int            k;
        int            j;
        int            busy;
        d = model_dec(o, f);
        r = model_res(d, aa, bb);
        k = s ? (DW + 3) / 4 : DW;
        @(negedge clk);
        sel = s; op = o; func = f; a = aa; b = bb;
        set_valid(1'b1);
        chk({tag, "_ready"}, 32'(s_ready), 32'd1);
        @(negedge clk);
        set_valid(1'b0);
        chk({tag, "_aluop"}, 32'(s_aluop), 32'(d));
        if (d != 3'b101) begin
            chk({tag, "_ovalid"}, 32'(s_ovalid), 32'd1);
            chk({tag, "_result"}, 32'(s_result), 32'(r));
            chk({tag, "_zero"}, 32'(s_zero), 32'(r == '0));
            chk({tag, "_illegal"}, 32'(s_illegal), 32'(d == 3'b111));
        end else begin
            j = 0;
            busy = 0;
            while (s_ovalid !== 1'b1 && j < 200) begin
                if (s_ready === 1'b0) busy++;
                if (scramble) begin
                    a = DW'($urandom);
                    b = DW'($urandom);
                    op = 5'($urandom);
                    func = 3'($urandom);
                    set_valid(1'b1);
                end
                @(negedge clk);
                j++;
            end
            set_valid(1'b0);
            chk({tag, "_latency"}, 32'(j), 32'(k));
            chk({tag, "_busy"}, 32'(busy), 32'(k));
            chk({tag, "_result"}, 32'(s_result), 32'(r));
            chk({tag, "_zero"}, 32'(s_zero), 32'(r == '0));
            chk({tag, "_illegal"}, 32'(s_illegal), 32'd0);
        end
        @(negedge clk);
        chk({tag, "_pulse_end"}, 32'(s_ovalid), 32'd0);
    endtask

    initial begin
        int issued;
        int cyc;
        int spur;
        int oi;
        sel = 1'b0;
        in_valid1 = 1'b0;
        in_valid4 = 1'b0;
        op = '0; func = '0; a = '0; b = '0;
        rst = 1'b1;

        #2;
        chk("rst_ready", 32'(ready1), 32'd1);
        chk("rst_aluop", 32'(aluop1), 32'd0);
        chk("rst_result", 32'(result1), 32'd0);
        chk("rst_zero", 32'(zero1), 32'd1);
        chk("rst_illegal", 32'(illegal1), 32'd0);
        chk("rst_ovalid", 32'(ovalid1), 32'd0);
        chk("rst_ready4", 32'(ready4), 32'd1);
        @(negedge clk);
        rst = 1'b0;

        // directed single-cycle operations
        run_req(1'b0, 5'b00000, 3'b010, 21'd5, 21'd7, 1'b0, "add");
        run_req(1'b0, 5'b01111, 3'b000, 21'd9, 21'd9, 1'b0, "beq");
        chk("beq_const_zero", 32'(zero1), 32'd1);
        run_req(1'b0, 5'b10010, 3'b000, 21'h1FFFFF, 21'd1, 1'b0, "slti");
        chk("slti_const", 32'(result1), 32'd1);
        run_req(1'b0, 5'b11000, 3'b000, 21'h0F0, 21'h00F, 1'b0, "ori");
        chk("ori_const", 32'(result1), 32'h0FF);
        run_req(1'b0, 5'b00000, 3'b001, 21'd3, 21'd5, 1'b0, "sub_wrap");
        run_req(1'b0, 5'b00000, 3'b011, 21'h1234F, 21'h0FF0F, 1'b0, "and");

        // multiplier, both step sizes, operands scrambled while busy
        run_req(1'b0, 5'b00000, 3'b100, 21'd1000, 21'd3000, 1'b1, "mul1");
        chk("mul1_const", 32'(result1), 32'd902848);
        run_req(1'b1, 5'b00000, 3'b100, 21'd1000, 21'd3000, 1'b1, "mul4");
        chk("mul4_const", 32'(result4), 32'd902848);
        run_req(1'b1, 5'b00000, 3'b100, 21'h1FFFFF, 21'h1FFFFF, 1'b0, "mul4_max");

        // illegal func and unknown opcode
        run_req(1'b0, 5'b00000, 3'b111, 21'd77, 21'd3, 1'b0, "illegal");
        chk("illegal_const", 32'(illegal1), 32'd1);
        run_req(1'b0, 5'b11111, 3'b111, 21'd4, 21'd6, 1'b0, "unknown_op");
        chk("unknown_op_const", 32'(illegal1), 32'd0);

        // random requests across both instances
        for (int i = 0; i < 40; i++) begin
            oi = $urandom_range(0, 8);
            run_req(1'($urandom_range(0, 1)), op_tab[oi], 3'($urandom_range(0, 7)),
                    DW'($urandom), DW'($urandom), 1'($urandom_range(0, 1)), "rand");
        end

        // in_valid held high, alternating ADD/MUL, scoreboarded in completion order
        @(negedge clk);
        sel = 1'b0;
        in_valid1 = 1'b1;
        issued = 0;
        cyc = 0;
        while ((issued < 6 || exp_q.size() > 0) && cyc < 500) begin
            if (ovalid1 === 1'b1) begin
                if (exp_q.size() == 0) chk("stream_spurious", 32'd1, 32'd0);
                else chk("stream_result", 32'(result1), 32'(exp_q.pop_front()));
            end
            if (ready1 === 1'b1 && issued < 6) begin
                op = 5'b00000;
                func = (issued % 2 == 1) ? 3'b100 : 3'b010;
                a = DW'($urandom);
                b = DW'($urandom);
                exp_q.push_back(model_res(model_dec(op, func), a, b));
                issued++;
            end else begin
                if (ready1 === 1'b1) in_valid1 = 1'b0;
                op = 5'($urandom);
                func = 3'($urandom);
                a = DW'($urandom);
                b = DW'($urandom);
            end
            @(negedge clk);
            cyc++;
        end
        in_valid1 = 1'b0;
        chk("stream_issued", 32'(issued), 32'd6);
        chk("stream_drained", 32'(exp_q.size()), 32'd0);

        // reset during the 10th multiply iteration aborts the request
        run_req(1'b0, 5'b00000, 3'b010, 21'd40, 21'd2, 1'b0, "pre_abort");
        @(negedge clk);
        sel = 1'b0; op = 5'b00000; func = 3'b100; a = 21'd1000; b = 21'd3000;
        in_valid1 = 1'b1;
        @(negedge clk);
        in_valid1 = 1'b0;
        repeat (9) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("abort_ready", 32'(ready1), 32'd1);
        chk("abort_aluop", 32'(aluop1), 32'd0);
        chk("abort_result", 32'(result1), 32'd0);
        chk("abort_zero", 32'(zero1), 32'd1);
        chk("abort_illegal", 32'(illegal1), 32'd0);
        chk("abort_ovalid", 32'(ovalid1), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        spur = 0;
        repeat (30) begin
            @(negedge clk);
            if (ovalid1 === 1'b1) spur++;
        end
        chk("abort_no_valid", 32'(spur), 32'd0);
        run_req(1'b0, 5'b00000, 3'b010, 21'd1, 21'd1, 1'b0, "post_abort_add");
        chk("post_abort_const", 32'(result1), 32'd2);

        // final report
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
